// File: rtl/tlb_inv_seq.sv
// tlb_inv_seq: INVTLB sequencer. Accepts one invalidate request, walks the
// TLB entries one per cycle, and clears the E bit of every matching entry.
// Optional feature macro: INVTLB_FAST_ALL_EN (ops 0/1 clear all entries in
// one cycle through clr_all instead of walking).
module tlb_inv_seq #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_op,
    input  logic [9:0]    req_asid,
    input  logic [18:0]   req_vppn,
    output logic [IW-1:0] rd_idx,
    input  logic          rd_e,
    input  logic          rd_g,
    input  logic [9:0]    rd_asid,
    input  logic [5:0]    rd_ps,
    input  logic [18:0]   rd_vppn,
    output logic          clr_en,
    output logic [IW-1:0] clr_idx,
    output logic          clr_all,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(TLBNUM - 1);
    localparam logic [4:0]    MAX_OP   = 5'd6;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [4:0]    op_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;
    logic          err_q;
    logic          accept;
    logic          op_legal;
    logic          va_hit;
    logic          asid_hit;
    logic          match;

    assign accept   = (state == IDLE) && req_valid;
    assign op_legal = (req_op <= MAX_OP);

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!op_legal) begin
                        state_next = FIN;
                    end else begin
`ifdef INVTLB_FAST_ALL_EN
                        state_next = (req_op <= 5'd1) ? FIN : SCAN;
`else
                        state_next = SCAN;
`endif
                    end
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request operands, walk index and latched error flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx    <= '0;
            op_q   <= '0;
            asid_q <= '0;
            vppn_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= req_op;
                asid_q <= req_asid;
                vppn_q <= req_vppn;
                idx    <= '0;
                err_q  <= !op_legal;
            end else if (state == SCAN) begin
                if (idx != LAST_IDX) begin
                    idx <= idx + IW'(1);
                end
            end else if (state == FIN) begin
                idx   <= '0;
                err_q <= 1'b0;
            end
        end
    end

`ifdef INVTLB_FAST_ALL_EN
    logic fast_q;

    // Marks an accepted op 0/1 that bypasses the walk
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fast_q <= 1'b0;
        end else if (accept) begin
            fast_q <= (req_op <= 5'd1);
        end else if (state == FIN) begin
            fast_q <= 1'b0;
        end
    end

    assign clr_all = (state == FIN) && fast_q;
`else
    assign clr_all = 1'b0;
`endif

    // Entry compare: a 2MB page (PS=21) compares only VPPN[18:9]
    always_comb begin
        asid_hit = (rd_asid == asid_q);
        if (rd_ps == 6'd21) begin
            va_hit = (rd_vppn[18:9] == vppn_q[18:9]);
        end else begin
            va_hit = (rd_vppn == vppn_q);
        end
        unique case (op_q)
            5'd0, 5'd1: match = 1'b1;
            5'd2:       match = rd_g;
            5'd3:       match = !rd_g;
            5'd4:       match = !rd_g && asid_hit;
            5'd5:       match = !rd_g && asid_hit && va_hit;
            5'd6:       match = (rd_g || asid_hit) && va_hit;
            default:    match = 1'b0;
        endcase
        match = match && rd_e;
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign err       = (state == FIN) && err_q;
    assign rd_idx    = idx;
    assign clr_idx   = idx;
    assign clr_en    = (state == SCAN) && match;

endmodule
